// File: rtl/uart_rx_buffer_pkg.sv
// Shared constants for the UART receive buffer: register indices,
// STATUS/CTRL bit positions and field offsets.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_NEMPTY  = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int CTRL_IRQEN = 0;
  localparam int CTRL_FLUSH = 1;

  localparam int CNT_LSB = 8;
  localparam int THR_LSB = 8;

  // Stored threshold width: AW+1 bits, but never wider than the 8-bit CTRL field.
  function automatic int thr_width(input int aw);
    return (aw + 1 > 8) ? 8 : aw + 1;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Receiver push strobe plus the register-bus signals of the RX buffer.
interface uart_rx_buffer_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output rx_byte, rx_valid, sel, we, addr, wdata,
                  input  rdata, irq);
  modport slave  (input  rx_byte, rx_valid, sel, we, addr, wdata,
                  output rdata, irq);
endinterface

// File: rtl/uart_sync_fifo.sv
// Power-of-two synchronous FIFO with flop storage and an asynchronous head read.
// Owns all pointer/count arithmetic, including the push-while-full-with-pop rule.
module uart_sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_nxt,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        push_ok, pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = mem[rptr];

  // Accept rules: a pop frees a slot for a same-cycle push; flush discards both.
  always_comb begin
    pop_ok    = pop & ~empty & ~flush;
    push_ok   = push & ~flush & (~full | pop_ok);
    count_nxt = count;
    if (flush)                 count_nxt = '0;
    else if (push_ok & ~pop_ok) count_nxt = count + CW'(1);
    else if (pop_ok & ~push_ok) count_nxt = count - CW'(1);
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_ok) wptr <= wptr + AW'(1);
        if (pop_ok)  rptr <= rptr + AW'(1);
      end
    end
  end

  // Storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART RX byte buffer: FIFO plus DATA/STATUS/CTRL register decode,
// sticky overrun flag, registered read data and level interrupt.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_buffer_if.slave  bus
);

  localparam int TW = thr_width(AW);

  logic          rd, wr, pop_req, ctrl_wr, flush, ovr_set, ovr_clr;
  logic          full, empty;
  logic [AW:0]   count, cnt_n, thr_ext;
  logic [7:0]    dout;
  logic          ovr, ovr_n, irq_en, irq_en_n, irq_n;
  logic [TW-1:0] thresh, thresh_n;
  logic [31:0]   status_w, ctrl_w, rd_word;

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.rx_valid),
    .din       (bus.rx_byte),
    .pop       (pop_req),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .count_nxt (cnt_n),
    .dout      (dout)
  );

  // Bus decode and next-state of the flag/control registers.
  always_comb begin
    rd       = bus.sel & ~bus.we;
    wr       = bus.sel &  bus.we;
    pop_req  = rd & (bus.addr == REG_DATA) & ~empty;
    ctrl_wr  = wr & (bus.addr == REG_CTRL);
    flush    = ctrl_wr & bus.wdata[CTRL_FLUSH];
    ovr_clr  = wr & (bus.addr == REG_STATUS) & bus.wdata[ST_OVR];
    // Dropped byte: full, nothing popped to make room, and not a flush cycle.
    ovr_set  = bus.rx_valid & full & ~pop_req & ~flush;
    ovr_n    = ovr_set | (ovr & ~ovr_clr);
    irq_en_n = ctrl_wr ? bus.wdata[CTRL_IRQEN] : irq_en;
    thresh_n = ctrl_wr ? bus.wdata[THR_LSB +: TW] : thresh;
    thr_ext  = '0;
    thr_ext[TW-1:0] = thresh_n;
    irq_n    = irq_en_n & (((thresh_n != '0) && (cnt_n >= thr_ext)) | ovr_n);
  end

  // Register read mux; STATUS/CTRL reflect pre-update state of this cycle.
  always_comb begin
    status_w             = '0;
    status_w[ST_NEMPTY]  = ~empty;
    status_w[ST_FULL]    = full;
    status_w[ST_OVR]     = ovr;
    status_w[CNT_LSB +: AW+1] = count;
    ctrl_w               = '0;
    ctrl_w[CTRL_IRQEN]   = irq_en;
    ctrl_w[THR_LSB +: TW] = thresh;
    unique case (bus.addr)
      REG_DATA:   rd_word = empty ? 32'd0 : {24'd0, dout};
      REG_STATUS: rd_word = status_w;
      REG_CTRL:   rd_word = ctrl_w;
      default:    rd_word = 32'd0;
    endcase
  end

  // Control/flag state, read-data capture and interrupt level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr       <= 1'b0;
      irq_en    <= 1'b0;
      thresh    <= '0;
      bus.rdata <= 32'd0;
      bus.irq   <= 1'b0;
    end else begin
      ovr     <= ovr_n;
      irq_en  <= irq_en_n;
      thresh  <= thresh_n;
      bus.irq <= irq_n;
      if (rd) bus.rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer; read data is checked by a scoreboard
// monitor, interrupt/reset levels by direct checks.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  typedef struct {
    logic [31:0] v;
    string       n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic rd_pend;

  uart_rx_buffer_if bus();

  uart_rx_buffer #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Note which cycles carried a read; rdata is compared half a cycle after.
  always @(posedge clk or negedge rst) begin
    if (!rst) rd_pend <= 1'b0;
    else      rd_pend <= bus.sel & ~bus.we;
  end

  // Scoreboard monitor: every read response pops one expected entry.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_read: got %h expected no read", bus.rdata);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.n, bus.rdata, mon_e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.sel = 1'b0; bus.we = 1'b0; bus.rx_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.rx_valid = 1'b1; bus.rx_byte = d;
    tick();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    sb.push_back('{e, n});
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
  endtask

  initial begin
    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0; bus.sel = 1'b0;
    bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", bus.rdata, 32'd0);
    check("reset_irq", {31'd0, bus.irq}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic push / pop / empty read
    push(8'h41); push(8'h42); push(8'h43);
    rd(REG_STATUS, 32'h0000_0301, "status_3");
    rd(REG_DATA, 32'h41, "data_41");
    rd(REG_DATA, 32'h42, "data_42");
    rd(REG_DATA, 32'h43, "data_43");
    rd(REG_DATA, 32'h00, "data_empty");
    rd(REG_STATUS, 32'h0000_0000, "status_empty");

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) push(8'(i));
    check("irq_ovr_disabled", {31'd0, bus.irq}, 32'd0);
    rd(REG_STATUS, 32'h0000_1007, "status_full_ovr");
    for (int i = 0; i < 16; i++) rd(REG_DATA, 32'(i), "data_ovf_drain");
    rd(REG_STATUS, 32'h0000_0004, "status_ovr_sticky");
    wr(REG_STATUS, 32'h0000_0004);
    rd(REG_STATUS, 32'h0000_0000, "status_ovr_w1c");

    // Full FIFO with same-cycle push and pop
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    bus.rx_valid = 1'b1; bus.rx_byte = 8'h90;
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = REG_DATA;
    sb.push_back('{32'h80, "data_full_pushpop"});
    tick();
    rd(REG_STATUS, 32'h0000_1003, "status_full_no_ovr");
    for (int i = 1; i <= 16; i++) rd(REG_DATA, 32'h80 + 32'(i), "data_pushpop_drain");
    rd(REG_STATUS, 32'h0000_0000, "status_drained");

    // Threshold interrupt
    wr(REG_CTRL, 32'h0000_0301);
    rd(REG_CTRL, 32'h0000_0301, "ctrl_readback");
    push(8'hA1); push(8'hA2);
    check("irq_below_thresh", {31'd0, bus.irq}, 32'd0);
    push(8'hA3);
    check("irq_at_thresh", {31'd0, bus.irq}, 32'd1);
    rd(REG_DATA, 32'hA1, "data_A1");
    check("irq_after_pop", {31'd0, bus.irq}, 32'd0);
    wr(REG_CTRL, 32'h0000_FF01);
    rd(REG_CTRL, 32'h0000_1F01, "ctrl_thresh_trunc");
    check("irq_high_thresh", {31'd0, bus.irq}, 32'd0);
    rd(REG_DATA, 32'hA2, "data_A2");
    rd(REG_DATA, 32'hA3, "data_A3");
    wr(REG_CTRL, 32'h0000_0000);

    // Flush with a same-cycle push
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
    bus.rx_valid = 1'b1; bus.rx_byte = 8'h55;
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = REG_CTRL; bus.wdata = 32'h0000_0002;
    tick();
    rd(REG_STATUS, 32'h0000_0000, "status_flushed");
    rd(REG_DATA, 32'h00, "data_after_flush");
    rd(REG_CTRL, 32'h0000_0000, "ctrl_flush_reads0");

    // Asynchronous reset mid-operation
    wr(REG_CTRL, 32'h0000_0201);
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    rd(REG_DATA, 32'hC0, "data_C0");
    tick();
    check("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
    check("pre_reset_rdata", bus.rdata, 32'hC0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_rdata", bus.rdata, 32'd0);
    check("async_rst_irq", {31'd0, bus.irq}, 32'd0);
    check("async_rst_count", 32'(dut.u_fifo.count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    push(8'hD1); push(8'hD2);
    rd(REG_STATUS, 32'h0000_0201, "status_post_reset");
    rd(REG_CTRL, 32'h0000_0000, "ctrl_post_reset");
    rd(REG_DATA, 32'hD1, "data_D1");
    rd(REG_DATA, 32'hD2, "data_D2");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'h0000_0000, "reserved_reads0");

    tick(); tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
